ssc_regfile_param: RTL and testbench

//   Parametrised, clocked register file for the single-cycle core. It replaces the fixed
//   8x32 combinational bank. It holds GPRs 1..NUM_REGS-1, the PC (aliased at address 0)
//   and a flags register. N combinational read ports feed the ALU; one write-back port is

---
 rtl/ssc_regfile_param.sv | 104 ++++++++++
 tb/tb_ssc_regfile_param.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ssc_regfile_param.sv
// Parametrised clocked register file: GPRs 1..NUM_REGS-1, PC aliased at address 0, and a flags
// register. It has NUM_RD combinational read ports and one write-back port.
module ssc_regfile_param #(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 3,
    parameter int                NUM_RD   = 2,
    parameter int                FLAG_W   = 4,
    parameter logic [DATA_W-1:0] PC_RESET = '0,
    parameter int                PC_STEP  = 4,
    parameter int                BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clk_en,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     pc_load,
    input  logic [DATA_W-1:0]        pc_in,
    input  logic [FLAG_W-1:0]        flags_we,
    input  logic [FLAG_W-1:0]        flags_in,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0]        pc_out,
    output logic [FLAG_W-1:0]        flags_out
);

    localparam int NUM_REGS = 1 << ADDR_W;

    // Entry 0 is never written; reads of address 0 are steered to the PC instead.
    logic [DATA_W-1:0] gpr_q [NUM_REGS];
    logic [DATA_W-1:0] pc_q;
    logic [DATA_W-1:0] pc_d;
    logic [FLAG_W-1:0] flags_q;

    logic gpr_we;
    logic pc_wr;
    logic fwd_active;

    // wr_en qualifies wr_addr/wr_data. No state is touched while it is low, so X on the data
    // and address lines is harmless.
    assign gpr_we = wr_en && (wr_addr != '0);
    assign pc_wr  = wr_en && (wr_addr == '0);

    // Forwarding needs rst_n so that rd_data reads as reset values while reset is asserted.
    assign fwd_active = (BYPASS != 0) && rst_n && clk_en && gpr_we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                gpr_q[i] <= '0;
            end
        end else if (clk_en && gpr_we) begin
            gpr_q[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        pc_d = pc_q + DATA_W'(PC_STEP);
        if (pc_wr) begin
            pc_d = wr_data;
        end else if (pc_load) begin
            pc_d = pc_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= PC_RESET;
        end else if (clk_en) begin
            pc_q <= pc_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= '0;
        end else if (clk_en) begin
            flags_q <= (flags_q & ~flags_we) | (flags_in & flags_we);
        end
    end

    assign pc_out    = pc_q;
    assign flags_out = flags_q;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] port_addr;
        logic [DATA_W-1:0] port_data;

        assign port_addr = rd_addr[k*ADDR_W +: ADDR_W];

        always_comb begin
            port_data = gpr_q[port_addr];
            if (port_addr == '0) begin
                port_data = pc_q;
            end else if (fwd_active && (port_addr == wr_addr)) begin
                port_data = wr_data;
            end
        end

        assign rd_data[k*DATA_W +: DATA_W] = port_data;
    end

endmodule

// File: tb/tb_ssc_regfile_param.sv
// Directed bench for ssc_regfile_param. It runs one instance with forwarding enabled and one
// without, both on shared stimulus, and compares each against hand-computed values.
module tb_ssc_regfile_param;

    localparam int DW = 32;
    localparam int AW = 3;
    localparam int NR = 2;
    localparam int FW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clk_en;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          pc_load;
    logic [DW-1:0] pc_in;
    logic [FW-1:0] flags_we;
    logic [FW-1:0] flags_in;
    logic [NR*AW-1:0] rd_addr;

    logic [NR*DW-1:0] rd_data,   rd_data_nb;
    logic [DW-1:0]    pc_out,    pc_out_nb;
    logic [FW-1:0]    flags_out, flags_out_nb;

    logic [DW-1:0] rd0, rd1, rd0_nb, rd1_nb;
    assign rd0    = rd_data[DW-1:0];
    assign rd1    = rd_data[2*DW-1:DW];
    assign rd0_nb = rd_data_nb[DW-1:0];
    assign rd1_nb = rd_data_nb[2*DW-1:DW];

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    ssc_regfile_param #(.BYPASS(1)) dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .pc_load(pc_load), .pc_in(pc_in), .flags_we(flags_we),
        .flags_in(flags_in), .rd_addr(rd_addr), .rd_data(rd_data), .pc_out(pc_out),
        .flags_out(flags_out)
    );

    ssc_regfile_param #(.BYPASS(0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .pc_load(pc_load), .pc_in(pc_in), .flags_we(flags_we),
        .flags_in(flags_in), .rd_addr(rd_addr), .rd_data(rd_data_nb), .pc_out(pc_out_nb),
        .flags_out(flags_out_nb)
    );

    // ---------------- driver tasks ----------------
    task automatic idle();
        clk_en   = 1'b0;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        pc_load  = 1'b0;
        pc_in    = '0;
        flags_we = '0;
        flags_in = '0;
    endtask

    task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rd_addr = {a1, a0};
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        idle();
        set_rd(3'd0, 3'd3);
        step();
        step();
        #2;
        // T1: reset values are visible while reset is held.
        check("t1_pc", pc_out, 32'h0);
        check("t1_flags", flags_out, 32'h0);
        check("t1_rd0_pc", rd0, 32'h0);
        check("t1_rd1_r3", rd1, 32'h0);

        rst_n = 1'b1;
        step();
        #1;
        check("stall_after_release_pc", pc_out, 32'h0);

        // T2: write r3, forwarded value before the edge, stored value after it.
        clk_en  = 1'b1;
        wr_en   = 1'b1;
        wr_addr = 3'd3;
        wr_data = 32'hDEADBEEF;
        set_rd(3'd3, 3'd3);
        #1;
        check("t2_fwd_rd0", rd0, 32'hDEADBEEF);
        check("t2_nofwd_rd0", rd0_nb, 32'h0);
        step();
        idle();
        #1;
        check("t2_rd0", rd0, 32'hDEADBEEF);
        check("t2_rd1", rd1, 32'hDEADBEEF);
        check("t2_nb_rd0", rd0_nb, 32'hDEADBEEF);
        check("t2_pc_step", pc_out, 32'h4);

        // T3: write r5 and read it on port 1 in the same cycle.
        clk_en  = 1'b1;
        wr_en   = 1'b1;
        wr_addr = 3'd5;
        wr_data = 32'h1234;
        set_rd(3'd3, 3'd5);
        #1;
        check("t3_fwd_rd1", rd1, 32'h1234);
        check("t3_nofwd_rd1", rd1_nb, 32'h0);
        check("t3_other_port", rd0, 32'hDEADBEEF);
        clk_en = 1'b0;
        #1;
        check("t3_stall_no_fwd", rd1, 32'h0);
        clk_en = 1'b1;
        step();
        idle();
        #1;
        check("t3_r5_stored", rd1, 32'h1234);
        check("t3_pc", pc_out, 32'h8);

        // T4: PC write port beats pc_load, then step and wrap.
        clk_en  = 1'b1;
        wr_en   = 1'b1;
        wr_addr = 3'd0;
        wr_data = 32'h100;
        set_rd(3'd0, 3'd5);
        #1;
        check("t4_addr0_not_fwd", rd0, 32'h8);
        step();
        pc_load = 1'b1;
        pc_in   = 32'h200;
        wr_data = 32'h300;
        #1;
        check("t4_pc_wr", pc_out, 32'h100);
        check("t4_rd0_is_pc", rd0, 32'h100);
        step();
        idle();
        clk_en = 1'b1;
        #1;
        check("t4_wr_beats_load", pc_out, 32'h300);
        step();
        #1;
        check("t4_step", pc_out, 32'h304);
        wr_en   = 1'b1;
        wr_addr = 3'd0;
        wr_data = 32'hFFFFFFFC;
        step();
        wr_en = 1'b0;
        #1;
        check("t4_pc_max", pc_out, 32'hFFFFFFFC);
        step();
        #1;
        check("t4_wrap", pc_out, 32'h0);
        pc_load = 1'b1;
        pc_in   = 32'h200;
        step();
        idle();
        #1;
        check("t4_load", pc_out, 32'h200);

        // T5: three stalled edges with every update request active.
        clk_en   = 1'b0;
        wr_en    = 1'b1;
        wr_addr  = 3'd3;
        wr_data  = 32'h0;
        pc_load  = 1'b1;
        pc_in    = 32'h55;
        flags_we = 4'hF;
        flags_in = 4'hF;
        set_rd(3'd3, 3'd5);
        #1;
        check("t5_no_fwd", rd0, 32'hDEADBEEF);
        repeat (3) step();
        #1;
        check("t5_pc", pc_out, 32'h200);
        check("t5_flags", flags_out, 32'h0);
        check("t5_r3", rd0, 32'hDEADBEEF);
        check("t5_r5", rd1, 32'h1234);

        // An enabled edge with wr_en low and unknown address/data.
        idle();
        clk_en  = 1'b1;
        wr_addr = 'x;
        wr_data = 'x;
        step();
        idle();
        #1;
        check("x_r3", rd0, 32'hDEADBEEF);
        check("x_pc", pc_out, 32'h204);

        // T6: masked flag writes.
        clk_en   = 1'b1;
        flags_we = 4'b0101;
        flags_in = 4'b1111;
        step();
        flags_we = 4'b0011;
        flags_in = 4'b0000;
        #1;
        check("t6_mask_set", flags_out, 32'h5);
        step();
        idle();
        #1;
        check("t6_mask_clr", flags_out, 32'h4);

        // Reset asserted mid-cycle while a write and a flag update are pending.
        clk_en   = 1'b1;
        wr_en    = 1'b1;
        wr_addr  = 3'd2;
        wr_data  = 32'hAAAA5555;
        flags_we = 4'hF;
        flags_in = 4'hF;
        set_rd(3'd2, 3'd0);
        #1;
        check("t6_pre_rst_fwd", rd0, 32'hAAAA5555);
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_rst_flags", flags_out, 32'h0);
        check("t6_rst_pc", pc_out, 32'h0);
        check("t6_rst_rd0_no_fwd", rd0, 32'h0);
        check("t6_rst_rd1_pc", rd1, 32'h0);
        step();
        idle();
        rst_n = 1'b1;
        #1;
        check("t6_r2_cleared", rd0, 32'h0);
        set_rd(3'd3, 3'd5);
        #1;
        check("t6_r3_cleared", rd0, 32'h0);
        check("t6_r5_cleared", rd1, 32'h0);
        check("t6_flags_after", flags_out, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
